// File: rtl/leaf_user_tx_packetizer.sv
// User-side transmit packetizer: wraps 32-bit user words into BFT packets gated by receiver credits.
// Optional statistics counters are enabled by defining PKT_TX_STATS_EN.
module leaf_user_tx_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    input  logic                     bft_ready,
    input  logic                     resend,
    input  logic                     credit_return,
`ifdef PKT_TX_STATS_EN
    output logic [31:0]              pkt_count,
    output logic [31:0]              stall_count,
`endif
    output logic                     credit_err
);

    localparam int CW           = NUM_ADDR_BITS + 1;
    localparam int MAX_CREDIT_I = 2 ** NUM_ADDR_BITS;
    localparam logic [CW:0] MAX_CREDIT = MAX_CREDIT_I[CW:0];
    localparam logic [CW:0] RET_INC    = FREESPACE_UPDATE_SIZE[CW:0];
    localparam logic [CW:0] ONE_CREDIT = {{CW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ACTIVE      = 2'd1,
        CREDIT_WAIT = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic [PAYLOAD_BITS-1:0]   mem_r [2];
    logic                      wr_ptr_r, rd_ptr_r;
    logic [1:0]                count_r, count_s;
    logic [NUM_ADDR_BITS-1:0]  addr_r;
    logic [CW-1:0]             credits_r, credits_s;
    logic [CW:0]               credit_sum_s;
    logic                      credit_over_s;
    logic                      credit_err_r;
    logic                      out_valid_r;
    logic [PACKET_BITS-2:0]    fields_r;
    logic                      empty_s, full_s, push_s, load_s, accept_s;
    logic                      fifo_wr_s, fifo_rd_s;
    logic [PAYLOAD_BITS-1:0]   load_word_s;

    assign empty_s  = (count_r == 2'd0);
    assign full_s   = (count_r == 2'd2);
    assign ack_interface2user = !full_s && (state_r != IDLE);
    assign push_s   = vld_user2interface && ack_interface2user;
    assign accept_s = out_valid_r && bft_ready && !resend;
    // An empty FIFO lets the incoming word go straight into the packet register.
    assign load_s   = (state_r == ACTIVE) && (credits_r != {CW{1'b0}}) &&
                      (!out_valid_r || accept_s) && (!empty_s || push_s);
    assign fifo_wr_s   = push_s && !(load_s && empty_s);
    assign fifo_rd_s   = load_s && !empty_s;
    assign load_word_s = empty_s ? din_leaf_user2interface : mem_r[rd_ptr_r];
    assign dout_leaf_interface2bft = (out_valid_r && !resend) ? {1'b1, fields_r}
                                                              : {PACKET_BITS{1'b0}};
    assign credit_err = credit_err_r;

    // Next FIFO occupancy from the write/read pair.
    always_comb begin
        count_s = count_r;
        case ({fifo_wr_s, fifo_rd_s})
            2'b10:   count_s = count_r + 2'd1;
            2'b01:   count_s = count_r - 2'd1;
            default: count_s = count_r;
        endcase
    end

    // Credit update with saturation; overflow is flagged instead of wrapped.
    always_comb begin
        credit_sum_s = {1'b0, credits_r};
        if (credit_return) begin
            credit_sum_s = credit_sum_s + RET_INC;
        end else begin
            credit_sum_s = credit_sum_s;
        end
        if (load_s) begin
            credit_sum_s = credit_sum_s - ONE_CREDIT;
        end else begin
            credit_sum_s = credit_sum_s;
        end
        credit_over_s = (credit_sum_s > MAX_CREDIT);
        if (credit_over_s) begin
            credits_s = MAX_CREDIT[CW-1:0];
        end else begin
            credits_s = credit_sum_s[CW-1:0];
        end
    end

    // Next-state logic for the injection control FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: state_s = ACTIVE;
            ACTIVE: begin
                if ((credits_r == {CW{1'b0}}) && !empty_s) begin
                    state_s = CREDIT_WAIT;
                end else begin
                    state_s = ACTIVE;
                end
            end
            CREDIT_WAIT: begin
                if (credit_return) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = CREDIT_WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, FIFO, credit and packet registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            mem_r[0]     <= {PAYLOAD_BITS{1'b0}};
            mem_r[1]     <= {PAYLOAD_BITS{1'b0}};
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            count_r      <= 2'd0;
            addr_r       <= {NUM_ADDR_BITS{1'b0}};
            credits_r    <= MAX_CREDIT[CW-1:0];
            credit_err_r <= 1'b0;
            out_valid_r  <= 1'b0;
            fields_r     <= {(PACKET_BITS-1){1'b0}};
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            credits_r <= credits_s;
            if (credit_over_s) begin
                credit_err_r <= 1'b1;
            end
            if (fifo_wr_s) begin
                mem_r[wr_ptr_r] <= din_leaf_user2interface;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (fifo_rd_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            if (load_s) begin
                out_valid_r <= 1'b1;
                fields_r    <= {dest_leaf, dest_port, addr_r, load_word_s};
                addr_r      <= addr_r + {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};
            end else if (accept_s) begin
                out_valid_r <= 1'b0;
                fields_r    <= {(PACKET_BITS-1){1'b0}};
            end
        end
    end

`ifdef PKT_TX_STATS_EN
    logic [31:0] pkt_count_r, stall_count_r;
    assign pkt_count   = pkt_count_r;
    assign stall_count = stall_count_r;

    // Accepted-packet and stalled-cycle counters, wrapping naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count_r   <= 32'd0;
            stall_count_r <= 32'd0;
        end else begin
            if (accept_s) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end
            if ((out_valid_r && !accept_s) || (state_r == CREDIT_WAIT)) begin
                stall_count_r <= stall_count_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_leaf_user_tx_packetizer.sv
// Directed self-checking bench for leaf_user_tx_packetizer (default build).
module tb_leaf_user_tx_packetizer;

    logic        clk;
    logic        reset_n;
    logic [31:0] din;
    logic        vld;
    logic        ack;
    logic [4:0]  dest_leaf;
    logic [3:0]  dest_port;
    logic [48:0] dout;
    logic        bft_ready;
    logic        resend;
    logic        credit_return;
    logic        credit_err;
`ifdef PKT_TX_STATS_EN
    logic [31:0] pkt_count, stall_count;
`endif

    int checks = 0;
    int errors = 0;
    int pushed;
    int emitted;
    logic xfer;
    logic [6:0] exp_addr;

    leaf_user_tx_packetizer dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .dest_leaf               (dest_leaf),
        .dest_port               (dest_port),
        .dout_leaf_interface2bft (dout),
        .bft_ready               (bft_ready),
        .resend                  (resend),
        .credit_return           (credit_return),
`ifdef PKT_TX_STATS_EN
        .pkt_count               (pkt_count),
        .stall_count             (stall_count),
`endif
        .credit_err              (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [48:0] pkt(input logic [6:0] a, input logic [31:0] d);
        return {1'b1, 5'd5, 4'd3, a, d};
    endfunction

    task automatic check(input string tag, input logic [48:0] obs, input logic [48:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; din = 32'd0; vld = 1'b0; dest_leaf = 5'd5; dest_port = 4'd3;
        bft_ready = 1'b0; resend = 1'b0; credit_return = 1'b0;
        tick(); tick();
        check("rst_dout", dout, 49'd0);
        check("rst_ack", {48'd0, ack}, 49'd0);
        check("rst_err", {48'd0, credit_err}, 49'd0);
        reset_n = 1'b1;
        #1;
        check("idle_ack", {48'd0, ack}, 49'd0);
        tick();
        check("active_ack", {48'd0, ack}, 49'd1);

        // Credit return while credits are full must flag an error and stay sticky.
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        check("err_set", {48'd0, credit_err}, 49'd1);
        tick(); tick(); tick();
        check("err_sticky", {48'd0, credit_err}, 49'd1);
        check("err_no_pkt", dout, 49'd0);

        // Basic packet format and next address.
        bft_ready = 1'b1; vld = 1'b1; din = 32'hDEADBEEF;
        tick();
        check("first_pkt", dout, 49'h1_2980_DEAD_BEEF);
        din = 32'h12345678;
        tick();
        check("second_pkt", dout, pkt(7'd1, 32'h12345678));
        vld = 1'b0;
        tick();
        check("drained", dout, 49'd0);

        // Back-pressure: packet held stable, FIFO fills, ack drops.
        bft_ready = 1'b0; vld = 1'b1; din = 32'hA0;
        tick();
        check("bp_c1", dout, pkt(7'd2, 32'hA0));
        din = 32'hA1;
        tick();
        check("bp_c2", dout, pkt(7'd2, 32'hA0));
        check("bp_ack1", {48'd0, ack}, 49'd1);
        din = 32'hA2;
        tick();
        check("bp_c3", dout, pkt(7'd2, 32'hA0));
        check("bp_ack_full", {48'd0, ack}, 49'd0);
        din = 32'hA3;
        tick();
        check("bp_c4", dout, pkt(7'd2, 32'hA0));
        vld = 1'b0;
        tick();
        check("bp_c5", dout, pkt(7'd2, 32'hA0));
        check("bp_ack_still0", {48'd0, ack}, 49'd0);
        bft_ready = 1'b1;
        tick();
        check("bp_rel1", dout, pkt(7'd3, 32'hA1));
        tick();
        check("bp_rel2", dout, pkt(7'd4, 32'hA2));
        tick();
        check("bp_empty", dout, 49'd0);
        check("bp_ack_back", {48'd0, ack}, 49'd1);

        // Resend blanks the output and the packet is re-presented once.
        vld = 1'b1; din = 32'hC0;
        tick();
        check("rs_load", dout, pkt(7'd5, 32'hC0));
        vld = 1'b0; resend = 1'b1;
        #1;
        check("rs_c1", dout, 49'd0);
        tick();
        check("rs_c2", dout, 49'd0);
        tick();
        check("rs_c3", dout, 49'd0);
        resend = 1'b0;
        #1;
        check("rs_rep", dout, pkt(7'd5, 32'hC0));
        tick();
        check("rs_once", dout, 49'd0);

        // Reset mid-packet discards the packet and the queued words.
        bft_ready = 1'b0; vld = 1'b1; din = 32'hE0;
        tick();
        din = 32'hE1;
        tick();
        din = 32'hE2;
        tick();
        vld = 1'b0;
        check("mr_pre_dout", dout, pkt(7'd6, 32'hE0));
        check("mr_pre_ack", {48'd0, ack}, 49'd0);
        reset_n = 1'b0;
        #1;
        check("mr_dout", dout, 49'd0);
        check("mr_ack", {48'd0, ack}, 49'd0);
        check("mr_err", {48'd0, credit_err}, 49'd0);
        tick();
        reset_n = 1'b1;
        tick();
        bft_ready = 1'b1; vld = 1'b1; din = 32'hF0;
        tick();
        check("mr_new", dout, pkt(7'd0, 32'hF0));
        vld = 1'b0;
        tick();
        check("mr_nostale1", dout, 49'd0);
        tick();
        check("mr_nostale2", dout, 49'd0);

        // Credit exhaustion: fresh reset, 130 words, 128 packets, then a return.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        pushed = 0; emitted = 0;
        for (int cyc = 0; cyc < 400 && pushed < 130; cyc++) begin
            vld = 1'b1;
            din = 32'h100 + pushed;
            xfer = ack;
            tick();
            if (xfer) pushed++;
            if (dout[48]) begin
                exp_addr = emitted[6:0];
                check("cr_pkt", dout, pkt(exp_addr, 32'h100 + emitted));
                emitted++;
            end
        end
        vld = 1'b0;
        check("cr_pushed", pushed, 49'd130);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dout[48]) begin
                exp_addr = emitted[6:0];
                check("cr_pkt_tail", dout, pkt(exp_addr, 32'h100 + emitted));
                emitted++;
            end
        end
        check("cr_emitted128", emitted, 49'd128);
        check("cr_ack_full", {48'd0, ack}, 49'd0);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (dout[48]) begin
                exp_addr = emitted[6:0];
                check("cr_wrap_pkt", dout, pkt(exp_addr, 32'h100 + emitted));
                emitted++;
            end
            tick();
        end
        check("cr_emitted130", emitted, 49'd130);
        check("cr_ack_back", {48'd0, ack}, 49'd1);
        check("cr_no_err", {48'd0, credit_err}, 49'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
